plic_irq_gateway: RTL and testbench

PLIC_IRQ_GATEWAY -- requirements
Module: plic_irq_gateway

---
 rtl/plic_pkg.sv | 13 +
 rtl/plic_sync_chain.sv | 20 ++
 rtl/plic_irq_gateway.sv | 85 ++++++++
 tb/tb_plic_irq_gateway.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared types and defaults for the PLIC interrupt gateway.
package plic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_INFLIGHT = 2'd2
  } gw_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 3;

endpackage

// File: rtl/plic_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input; reset clears every stage.
module plic_sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clock) begin
    if (reset) stage <= '0;
    else       stage <= {stage[DEPTH-2:0], d};
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/plic_irq_gateway.sv
// PLIC interrupt gateway: synchronizes a source, tracks pending edges (edge mode)
// and runs the request / in-flight / complete handshake toward the PLIC.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// ST_IDLE     | nothing outstanding; waits for src level or count > 0
// ST_REQ      | io_plic_valid high, held until the PLIC accepts it
// ST_INFLIGHT | accepted by the PLIC, waiting for the completion pulse
module plic_irq_gateway
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int EDGE        = 0,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic io_interrupt,
  output logic io_plic_valid,
  input  logic io_plic_ready,
  input  logic io_plic_complete,
  output logic io_dropped
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  gw_state_e        state, state_nxt;
  logic             src, src_q;
  logic             rise, accept, pending;
  logic [CNT_W-1:0] pend_cnt, cnt_nxt;
  logic             dropped_q, drop_nxt;

  plic_sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (io_interrupt),
    .q     (src)
  );

  assign rise    = src & ~src_q;
  assign accept  = (state == ST_REQ) & io_plic_ready;
  assign pending = (EDGE != 0) ? (pend_cnt != '0) : src;

  // A rise and an accept in the same cycle cancel, so saturation cannot drop that edge.
  always_comb begin
    cnt_nxt  = pend_cnt;
    drop_nxt = 1'b0;
    if (EDGE != 0) begin
      if (rise && !accept) begin
        if (pend_cnt == CNT_MAX) drop_nxt = 1'b1;
        else                     cnt_nxt  = pend_cnt + 1'b1;
      end else if (!rise && accept) begin
        cnt_nxt = pend_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (pending)          state_nxt = ST_REQ;
      ST_REQ:      if (io_plic_ready)    state_nxt = ST_INFLIGHT;
      ST_INFLIGHT: if (io_plic_complete) state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      src_q     <= 1'b0;
      pend_cnt  <= '0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      src_q     <= src;
      pend_cnt  <= cnt_nxt;
      dropped_q <= drop_nxt;
    end
  end

  assign io_plic_valid = (state == ST_REQ);
  assign io_dropped    = dropped_q;

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Directed bench for the gateway: one level-mode and one edge-mode instance.
module tb_plic_irq_gateway;
  import plic_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic l_reset, l_intr, l_valid, l_ready, l_complete, l_dropped;
  logic e_reset, e_intr, e_valid, e_ready, e_complete, e_dropped;

  int n_checks = 0;
  int n_errors = 0;
  int e_drop_cnt = 0;
  logic tie_phase = 1'b0;
  logic tie_seen  = 1'b0;

  plic_irq_gateway #(.SYNC_STAGES(2), .EDGE(0), .CNT_W(3)) dut_l (
    .clock            (clock),
    .reset            (l_reset),
    .io_interrupt     (l_intr),
    .io_plic_valid    (l_valid),
    .io_plic_ready    (l_ready),
    .io_plic_complete (l_complete),
    .io_dropped       (l_dropped)
  );

  plic_irq_gateway #(.SYNC_STAGES(2), .EDGE(1), .CNT_W(3)) dut_e (
    .clock            (clock),
    .reset            (e_reset),
    .io_interrupt     (e_intr),
    .io_plic_valid    (e_valid),
    .io_plic_ready    (e_ready),
    .io_plic_complete (e_complete),
    .io_dropped       (e_dropped)
  );

  always @(negedge clock) if (e_dropped) e_drop_cnt++;
  always @(negedge clock)
    if (tie_phase && (l_valid || l_dropped || e_valid || e_dropped)) tie_seen <= 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic e_pulse();
    e_intr = 1'b1;
    tick();
    e_intr = 1'b0;
    tick(3);
  endtask

  initial begin
    int drop_base;
    int episodes;
    int budget;

    l_reset = 1'b1; l_intr = 1'b0; l_ready = 1'b0; l_complete = 1'b0;
    e_reset = 1'b1; e_intr = 1'b0; e_ready = 1'b0; e_complete = 1'b0;
    tick(2);
    check_eq("rst_l_valid", 32'(l_valid), 0);
    check_eq("rst_l_state", 32'(dut_l.state), 32'(ST_IDLE));
    check_eq("rst_e_valid", 32'(e_valid), 0);
    check_eq("rst_e_dropped", 32'(e_dropped), 0);
    check_eq("rst_e_count", 32'(dut_e.pend_cnt), 0);
    l_reset = 1'b0;
    e_reset = 1'b0;
    tick();

    // level mode: cycle 0 raises the source
    l_intr = 1'b1;
    tick();   // cycle 1
    check_eq("lvl_c1_valid", 32'(l_valid), 0);
    tick();   // cycle 2
    check_eq("lvl_c2_valid", 32'(l_valid), 0);
    tick();   // cycle 3
    check_eq("lvl_c3_valid", 32'(l_valid), 1);
    l_complete = 1'b1;
    tick();   // cycle 4
    l_complete = 1'b0;
    check_eq("lvl_stray_complete_in_req", 32'(l_valid), 1);
    tick();   // cycle 5
    check_eq("lvl_c5_valid", 32'(l_valid), 1);
    l_intr = 1'b0;
    tick();   // cycle 6
    check_eq("lvl_no_retract", 32'(l_valid), 1);
    l_ready = 1'b1;
    tick();   // cycle 7
    l_ready = 1'b0;
    check_eq("lvl_c7_valid", 32'(l_valid), 0);
    check_eq("lvl_c7_state", 32'(dut_l.state), 32'(ST_INFLIGHT));
    l_intr = 1'b1;
    tick();   // cycle 8
    l_ready = 1'b1;
    tick();   // cycle 9
    l_ready = 1'b0;
    check_eq("lvl_ready_in_inflight", 32'(dut_l.state), 32'(ST_INFLIGHT));
    tick();   // cycle 10
    check_eq("lvl_c10_valid", 32'(l_valid), 0);
    l_complete = 1'b1;
    tick();   // cycle 11
    l_complete = 1'b0;
    check_eq("lvl_c11_state", 32'(dut_l.state), 32'(ST_IDLE));
    check_eq("lvl_c11_valid", 32'(l_valid), 0);
    tick();   // cycle 12
    check_eq("lvl_c12_valid", 32'(l_valid), 1);
    l_intr  = 1'b0;
    l_ready = 1'b1;
    tick();
    l_ready    = 1'b0;
    l_complete = 1'b1;
    tick();
    l_complete = 1'b0;
    tick(3);
    check_eq("lvl_quiet_valid", 32'(l_valid), 0);
    check_eq("lvl_dropped", 32'(l_dropped), 0);

    // edge mode: first edge latency, then saturation
    drop_base = e_drop_cnt;
    e_intr = 1'b1;
    tick();   // cycle 1
    e_intr = 1'b0;
    tick(2);  // cycle 3
    check_eq("edge_c3_valid", 32'(e_valid), 0);
    check_eq("edge_c3_count", 32'(dut_e.pend_cnt), 1);
    tick();   // cycle 4
    check_eq("edge_c4_valid", 32'(e_valid), 1);
    repeat (7) e_pulse();
    tick(2);
    check_eq("edge_sat_count", 32'(dut_e.pend_cnt), 7);
    check_eq("edge_sat_drops", 32'(e_drop_cnt - drop_base), 1);
    check_eq("edge_sat_valid", 32'(e_valid), 1);

    // rise coincident with accept at saturation
    e_intr = 1'b1;
    tick();
    e_intr = 1'b0;
    tick();
    e_ready = 1'b1;
    tick();
    e_ready = 1'b0;
    check_eq("edge_coinc_count", 32'(dut_e.pend_cnt), 7);
    check_eq("edge_coinc_dropped", 32'(e_dropped), 0);
    check_eq("edge_coinc_state", 32'(dut_e.state), 32'(ST_INFLIGHT));
    tick();
    check_eq("edge_coinc_dropped2", 32'(e_dropped), 0);
    e_complete = 1'b1;
    tick();
    e_complete = 1'b0;

    episodes = 0;
    for (int i = 0; i < 7; i++) begin
      budget = 10;
      while (!e_valid && budget > 0) begin
        tick();
        budget--;
      end
      if (!e_valid) begin
        check_eq("edge_episode_timeout", 32'(i), 7);
        break;
      end
      episodes++;
      e_ready = 1'b1;
      tick();
      e_ready    = 1'b0;
      e_complete = 1'b1;
      tick();
      e_complete = 1'b0;
    end
    tick(10);
    check_eq("edge_episodes", 32'(episodes), 7);
    check_eq("edge_drain_valid", 32'(e_valid), 0);
    check_eq("edge_drain_count", 32'(dut_e.pend_cnt), 0);
    check_eq("edge_total_drops", 32'(e_drop_cnt - drop_base), 1);

    // reset while in flight
    e_pulse();
    check_eq("rst_pre_valid", 32'(e_valid), 1);
    e_ready = 1'b1;
    tick();
    e_ready = 1'b0;
    e_pulse();
    check_eq("rst_pre_count", 32'(dut_e.pend_cnt), 1);
    check_eq("rst_pre_state", 32'(dut_e.state), 32'(ST_INFLIGHT));
    e_reset = 1'b1;
    e_ready = 1'b1;
    tick();
    e_reset = 1'b0;
    e_ready = 1'b0;
    check_eq("rst_inflight_valid", 32'(e_valid), 0);
    check_eq("rst_inflight_count", 32'(dut_e.pend_cnt), 0);
    check_eq("rst_inflight_state", 32'(dut_e.state), 32'(ST_IDLE));
    e_complete = 1'b1;
    tick();
    e_complete = 1'b0;
    tick(3);
    check_eq("rst_stray_complete_state", 32'(dut_e.state), 32'(ST_IDLE));
    check_eq("rst_stray_complete_valid", 32'(e_valid), 0);

    // tied-off source with random handshake noise
    l_intr = 1'b0;
    e_intr = 1'b0;
    tie_phase = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      l_ready    = 1'($urandom_range(0, 1));
      l_complete = 1'($urandom_range(0, 1));
      e_ready    = 1'($urandom_range(0, 1));
      e_complete = 1'($urandom_range(0, 1));
      tick();
    end
    tie_phase  = 1'b0;
    l_ready    = 1'b0;
    l_complete = 1'b0;
    e_ready    = 1'b0;
    e_complete = 1'b0;
    check_eq("tieoff_activity", 32'(tie_seen), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
